// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF challenge controller.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    COMPARE,
    DONE
  } puf_state_t;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_SEL_W      = 5;
  localparam int DEF_RESP_BITS  = 8;
  localparam int DEF_WINDOW     = 1024;
  localparam int DEF_CLR_CYC    = 2;
  localparam int DEF_SETTLE_CYC = 4;

  // 10-bit Fibonacci LFSR, x^10 + x^7 + 1
  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  // Padding above the 8-bit seed; the 1 in bit 8 keeps the LFSR out of the all-zero lockup state
  localparam logic [1:0] SEED_PAD = 2'b01;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_lfsr10.sv
// Challenge sequence generator: loads from the seed, steps once per response bit.
module puf_lfsr10
  import puf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [7:0]        seed,
  output logic [LFSR_W-1:0] value
);

  // Seed load has priority over stepping; otherwise the state holds
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= {SEED_PAD, seed};
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/puf_response_reader.sv
// Ring-oscillator PUF reader: per challenge clears both counter banks, runs the
// oscillators for a fixed window, lets the counts settle, then compares them
// to produce one response bit. The assembled response leaves via valid/ready.
module puf_response_reader
  import puf_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RESP_BITS  = DEF_RESP_BITS,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int CLR_CYC    = DEF_CLR_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           seed,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 osc_en,
  output logic                 cnt_clr,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic                 tie
);

  localparam int PH_MAX = max3(WINDOW, CLR_CYC, SETTLE_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [PH_W-1:0]  CLR_LAST    = PH_W'(CLR_CYC - 1);
  localparam logic [PH_W-1:0]  RUN_LAST    = PH_W'(WINDOW - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

  puf_state_t         state;
  logic [PH_W-1:0]    phase;
  logic [IDX_W-1:0]   bit_idx;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  lfsr_nxt;
  logic               lfsr_load;
  logic               lfsr_adv;
  logic [SEL_W-1:0]   sel_a_nxt;
  logic [SEL_W-1:0]   sel_b_raw;
  logic [SEL_W-1:0]   sel_b_nxt;
  logic               last_bit;
  logic               resp_bit;
  logic               counts_tie;

  assign last_bit   = (bit_idx == IDX_LAST);
  assign lfsr_load  = (state == IDLE) && start;
  assign lfsr_adv   = (state == COMPARE) && !last_bit;
  assign resp_bit   = (count_a > count_b);
  assign counts_tie = (count_a == count_b);

  puf_lfsr10 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (seed),
    .value   (lfsr_q)
  );

  // Selects are registered on the same edge the LFSR updates, so derive them from its upcoming value
  always_comb begin
    lfsr_nxt = lfsr_q;
    if (lfsr_load) begin
      lfsr_nxt = {SEED_PAD, seed};
    end else if (lfsr_adv) begin
      lfsr_nxt = lfsr_step(lfsr_q);
    end
  end

  // Never point both banks at the same oscillator: flip the LSB of bank B on a collision
  always_comb begin
    sel_a_nxt = lfsr_nxt[SEL_W-1:0];
    sel_b_raw = lfsr_nxt[2*SEL_W-1:SEL_W];
    sel_b_nxt = (sel_b_raw == sel_a_nxt) ? (sel_b_raw ^ SEL_W'(1)) : sel_b_raw;
  end

  // Main sequencer: every output is set on the edge that enters its phase
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      osc_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      tie        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            phase   <= '0;
            bit_idx <= '0;
            resp    <= '0;
            tie     <= 1'b0;
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
            sel_a   <= sel_a_nxt;
            sel_b   <= sel_b_nxt;
          end
        end
        CLEAR: begin
          if (phase == CLR_LAST) begin
            state   <= RUN;
            phase   <= '0;
            cnt_clr <= 1'b0;
            osc_en  <= 1'b1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        RUN: begin
          if (phase == RUN_LAST) begin
            state  <= SETTLE;
            phase  <= '0;
            osc_en <= 1'b0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        SETTLE: begin
          if (phase == SETTLE_LAST) begin
            state <= COMPARE;
            phase <= '0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        COMPARE: begin
          resp <= {resp[RESP_BITS-2:0], resp_bit};
          if (counts_tie) begin
            tie <= 1'b1;
          end
          if (last_bit) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            state   <= CLEAR;
            bit_idx <= bit_idx + IDX_W'(1);
            cnt_clr <= 1'b1;
            sel_a   <= sel_a_nxt;
            sel_b   <= sel_b_nxt;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_reader.sv
// Scenario bench for puf_response_reader with a short window and 4-bit responses.
module tb_puf_response_reader;

  localparam int CNT_W = 32;
  localparam int SEL_W = 5;
  localparam int RB    = 4;
  localparam int WIN   = 8;
  localparam int CLRC  = 2;
  localparam int SETC  = 4;
  localparam int T     = CLRC + WIN + SETC + 1;
  localparam int LAT   = RB * T;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       seed;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             osc_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic [RB-1:0]    resp;
  logic             resp_valid;
  logic             resp_ready;
  logic             busy;
  logic             tie;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic [RB-1:0] resp;
    logic          tie;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] tab_a[RB];
  logic [CNT_W-1:0] tab_b[RB];
  logic [SEL_W-1:0] obs_sa[RB];
  logic [SEL_W-1:0] obs_sb[RB];
  int               obs_clr[RB];
  int               obs_osc[RB];
  int               valid_cyc;
  int               overlap;

  puf_response_reader #(
    .CNT_W(CNT_W), .SEL_W(SEL_W), .RESP_BITS(RB),
    .WINDOW(WIN), .CLR_CYC(CLRC), .SETTLE_CYC(SETC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .osc_en     (osc_en),
    .cnt_clr    (cnt_clr),
    .count_a    (count_a),
    .count_b    (count_b),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy),
    .tie        (tie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected response: first bit lands in the MSB; equal counts give 0 and set tie
  function automatic exp_t model_resp();
    exp_t e;
    e = '0;
    for (int i = 0; i < RB; i++) begin
      e.resp = {e.resp[RB-2:0], (tab_a[i] > tab_b[i])};
      if (tab_a[i] == tab_b[i]) e.tie = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [9:0] model_lfsr(input logic [7:0] s, input int n);
    logic [9:0] v;
    v = {2'b01, s};
    for (int i = 0; i < n; i++) v = {v[8:0], v[9] ^ v[6]};
    return v;
  endfunction

  function automatic logic [SEL_W-1:0] model_sel_b(input logic [9:0] v);
    return (v[9:5] == v[4:0]) ? (v[9:5] ^ 5'd1) : v[9:5];
  endfunction

  task automatic do_start(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    exp_q.push_back(model_resp());
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge just after the accepting edge; feeds counts per bit and records activity
  task automatic run_bits();
    logic prev_clr;
    int   b;
    prev_clr  = 1'b0;
    b         = -1;
    valid_cyc = -1;
    overlap   = 0;
    for (int i = 0; i < RB; i++) begin
      obs_clr[i] = 0;
      obs_osc[i] = 0;
      obs_sa[i]  = '0;
      obs_sb[i]  = '0;
    end
    for (int c = 0; c < LAT + 40; c++) begin
      if (cnt_clr && osc_en) overlap++;
      if (cnt_clr && !prev_clr) begin
        b++;
        if (b < RB) begin
          obs_sa[b] = sel_a;
          obs_sb[b] = sel_b;
          count_a   = tab_a[b];
          count_b   = tab_b[b];
        end
      end
      if (b >= 0 && b < RB) begin
        if (cnt_clr) obs_clr[b]++;
        if (osc_en)  obs_osc[b]++;
      end
      prev_clr = cnt_clr;
      if (resp_valid) begin
        valid_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sel_a, sel_b, osc_en, cnt_clr, resp, resp_valid, busy, tie} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got sa=%0d sb=%0d osc=%b clr=%b resp=%b v=%b busy=%b tie=%b, want all 0",
               sel_a, sel_b, osc_en, cnt_clr, resp, resp_valid, busy, tie);
    end
    rst_n = 1'b0;
    do_start(8'h3C);
    n_cmp++;
    if (cnt_clr !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_pre_clear: got cnt_clr=%b, want 1", cnt_clr);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({cnt_clr, busy, sel_a, sel_b} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got clr=%b busy=%b sa=%0d sb=%0d, want all 0", cnt_clr, busy, sel_a, sel_b);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_basic();
    exp_t       e;
    logic [9:0] v;
    for (int i = 0; i < RB; i++) begin
      tab_a[i] = 100;
      tab_b[i] = 50;
    end
    resp_ready = 1'b1;
    do_start(8'h00);
    run_bits();
    n_cmp++;
    if (valid_cyc != LAT) begin
      n_bad++;
      $display("[TB] FAIL basic_latency: got %0d cycles, want %0d", valid_cyc, LAT);
    end
    n_cmp++;
    if ({obs_sa[0], obs_sb[0]} !== {5'd0, 5'd8}) begin
      n_bad++;
      $display("[TB] FAIL basic_first_sel: got a=%0d b=%0d, want a=0 b=8", obs_sa[0], obs_sb[0]);
    end
    for (int i = 0; i < RB; i++) begin
      v = model_lfsr(8'h00, i);
      n_cmp++;
      if ({obs_sa[i], obs_sb[i]} !== {v[4:0], model_sel_b(v)}) begin
        n_bad++;
        $display("[TB] FAIL basic_sel bit%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                 i, obs_sa[i], obs_sb[i], v[4:0], model_sel_b(v));
      end
      n_cmp++;
      if (obs_clr[i] != CLRC || obs_osc[i] != WIN) begin
        n_bad++;
        $display("[TB] FAIL basic_phase bit%0d: got clr=%0d osc=%0d, want clr=%0d osc=%0d",
                 i, obs_clr[i], obs_osc[i], CLRC, WIN);
      end
    end
    n_cmp++;
    if (overlap != 0) begin
      n_bad++;
      $display("[TB] FAIL basic_overlap: got %0d cycles with osc_en&cnt_clr, want 0", overlap);
    end
    n_cmp++;
    if ({resp, tie} !== {4'b1111, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL basic_resp: got resp=%b tie=%b, want resp=1111 tie=0", resp, tie);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL basic_scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      if ({resp, tie} !== e) begin
        n_bad++;
        $display("[TB] FAIL basic_scoreboard: got resp=%b tie=%b, want resp=%b tie=%b", resp, tie, e.resp, e.tie);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, resp_valid} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL basic_handshake: got busy=%b valid=%b, want 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_tie_order();
    exp_t e;
    tab_a[0] = 5; tab_b[0] = 9;
    tab_a[1] = 9; tab_b[1] = 5;
    tab_a[2] = 7; tab_b[2] = 7;
    tab_a[3] = 9; tab_b[3] = 5;
    resp_ready = 1'b1;
    do_start(8'hA5);
    run_bits();
    n_cmp++;
    if (valid_cyc != LAT) begin
      n_bad++;
      $display("[TB] FAIL tie_latency: got %0d cycles, want %0d", valid_cyc, LAT);
    end
    n_cmp++;
    if ({resp, tie} !== {4'b0101, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL tie_resp: got resp=%b tie=%b, want resp=0101 tie=1", resp, tie);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL tie_scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      if ({resp, tie} !== e) begin
        n_bad++;
        $display("[TB] FAIL tie_scoreboard: got resp=%b tie=%b, want resp=%b tie=%b", resp, tie, e.resp, e.tie);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    exp_t       e;
    logic [9:0] v;
    tab_a[0] = 1; tab_b[0] = 2;
    tab_a[1] = 2; tab_b[1] = 1;
    tab_a[2] = 1; tab_b[2] = 2;
    tab_a[3] = 2; tab_b[3] = 1;
    resp_ready = 1'b1;
    do_start(8'h08);
    run_bits();
    n_cmp++;
    if ({obs_sa[0], obs_sb[0]} !== {5'd8, 5'd9}) begin
      n_bad++;
      $display("[TB] FAIL collision_sel: got a=%0d b=%0d, want a=8 b=9", obs_sa[0], obs_sb[0]);
    end
    for (int i = 1; i < RB; i++) begin
      v = model_lfsr(8'h08, i);
      n_cmp++;
      if ({obs_sa[i], obs_sb[i]} !== {v[4:0], model_sel_b(v)}) begin
        n_bad++;
        $display("[TB] FAIL collision_sel bit%0d: got a=%0d b=%0d, want a=%0d b=%0d",
                 i, obs_sa[i], obs_sb[i], v[4:0], model_sel_b(v));
      end
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL collision_scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      if ({resp, tie} !== e) begin
        n_bad++;
        $display("[TB] FAIL collision_scoreboard: got resp=%b tie=%b, want resp=%b tie=%b", resp, tie, e.resp, e.tie);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    tab_a[0] = 20; tab_b[0] = 10;
    tab_a[1] = 10; tab_b[1] = 20;
    tab_a[2] = 20; tab_b[2] = 10;
    tab_a[3] = 20; tab_b[3] = 10;
    resp_ready = 1'b0;
    do_start(8'hC3);
    run_bits();
    n_cmp++;
    if (valid_cyc != LAT) begin
      n_bad++;
      $display("[TB] FAIL bp_latency: got %0d cycles, want %0d", valid_cyc, LAT);
    end
    e = '0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL bp_scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      if ({resp, tie} !== e) begin
        n_bad++;
        $display("[TB] FAIL bp_scoreboard: got resp=%b tie=%b, want resp=%b tie=%b", resp, tie, e.resp, e.tie);
      end
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({resp_valid, busy, resp, tie} !== {2'b11, e}) begin
        n_bad++;
        $display("[TB] FAIL bp_hold cyc%0d: got v=%b busy=%b resp=%b tie=%b, want v=1 busy=1 resp=%b tie=%b",
                 k, resp_valid, busy, resp, tie, e.resp, e.tie);
      end
      seed  = 8'hFF;
      start = (k % 2 == 0);
      @(negedge clk);
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, busy, resp, tie} !== {2'b00, e}) begin
      n_bad++;
      $display("[TB] FAIL bp_release: got v=%b busy=%b resp=%b tie=%b, want v=0 busy=0 resp=%b tie=%b",
               resp_valid, busy, resp, tie, e.resp, e.tie);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, cnt_clr} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL bp_no_queue: got busy=%b clr=%b, want 0 0", busy, cnt_clr);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    for (int i = 0; i < RB; i++) begin
      tab_a[i] = 40;
      tab_b[i] = 30;
    end
    resp_ready = 1'b1;
    do_start(8'h5A);
    for (int i = 0; i < 20 && !osc_en; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (osc_en !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midrun_pre: got osc_en=%b, want 1", osc_en);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({osc_en, busy, cnt_clr} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL midrun_reset: got osc=%b busy=%b clr=%b, want 0 0 0", osc_en, busy, cnt_clr);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    do_start(8'h5A);
    run_bits();
    n_cmp++;
    if (valid_cyc != LAT) begin
      n_bad++;
      $display("[TB] FAIL midrun_latency: got %0d cycles, want %0d", valid_cyc, LAT);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL midrun_scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      if ({resp, tie} !== e) begin
        n_bad++;
        $display("[TB] FAIL midrun_scoreboard: got resp=%b tie=%b, want resp=%b tie=%b", resp, tie, e.resp, e.tie);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b1;
    start      = 1'b0;
    seed       = '0;
    count_a    = '0;
    count_b    = '0;
    resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie_order();
    test_collision();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by 100000, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
